alu_nibble_sequencer: RTL and testbench

- Initiator side of the team's 4-bit combinational ALU interface.
- Accepts wide (4*NIBBLES-bit) operation commands over a valid/ready handshake.
- Drives the 4-bit ALU one nibble per cycle, LSB nibble first. It chains carry/borrow by issuing an extra ALU correction op, because the ALU has no carry-in.
- Returns the assembled result over a valid/ready response channel. Sits between the command source and one ALU instance.

---
 rtl/alu_nibble_sequencer.sv | 87 ++++++++
 tb/tb_alu_nibble_sequencer.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/alu_nibble_sequencer.sv
// alu_nibble_sequencer: runs wide ADD/SUB/logic commands through a 4-bit carry-less ALU one nibble per cycle.
module alu_nibble_sequencer #(
  parameter int NIBBLES = 4,
  localparam int WIDTH = 4 * NIBBLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_carry,
  output logic             rsp_err,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [2:0]       alu_sel,
  input  logic [3:0]       alu_result,
  input  logic             alu_carry
);
  typedef enum logic [1:0] {IDLE, OP, FIX, DONE} state_t;
  state_t state, state_next;
  logic [2:0] op, idx, nxt;
  logic [WIDTH-1:0] a, b, result;
  logic cr, c1, err, arith, last, bad;
  assign cmd_ready = state == IDLE;
  assign rsp_valid = state == DONE;
  assign rsp_result = result;
  assign rsp_carry = cr;
  assign rsp_err = err;
  always_comb begin
    arith = op[2:1] == 2'b00;
    last = idx == 3'(NIBBLES - 1);
    nxt = idx + 3'd1;
    bad = cmd_op == 3'b101 || cmd_op == 3'b110;
    state_next = state == IDLE ? (cmd_valid ? (bad ? DONE : OP) : IDLE)
               : state == OP   ? (arith && cr ? FIX : last ? DONE : OP)
               : state == FIX  ? (last ? DONE : OP)
               : (rsp_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      op <= 3'b000;
      a <= '0;
      b <= '0;
      idx <= 3'd0;
      result <= '0;
      cr <= 1'b0;
      c1 <= 1'b0;
      err <= 1'b0;
      alu_a <= 4'h0;
      alu_b <= 4'h0;
      alu_sel <= 3'b000;
    end else begin
      state <= state_next;
      if (state == IDLE && cmd_valid) begin
        op <= cmd_op;
        a <= cmd_a;
        b <= cmd_b;
        idx <= 3'd0;
        result <= '0;
        cr <= 1'b0;
        c1 <= 1'b0;
        err <= bad;
        alu_a <= bad ? 4'h0 : cmd_a[3:0];
        alu_b <= bad || cmd_op == 3'b111 ? 4'h0 : cmd_b[3:0];
        alu_sel <= bad ? 3'b000 : cmd_op;
      end else if (state == OP && arith && cr) begin
        // incoming carry/borrow: feed the raw nibble back through the ALU with +/-1
        c1 <= alu_carry;
        alu_a <= alu_result;
        alu_b <= 4'h1;
      end else if (state == OP || state == FIX) begin
        result[4*idx +: 4] <= alu_result;
        cr <= state == FIX ? (c1 | alu_carry) : (arith & alu_carry);
        idx <= last ? idx : nxt;
        alu_a <= last ? 4'h0 : a[4*nxt +: 4];
        alu_b <= last || op == 3'b111 ? 4'h0 : b[4*nxt +: 4];
        alu_sel <= last ? 3'b000 : op;
      end
    end
  end
endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// tb_alu_nibble_sequencer: scoreboard bench with a behavioural 4-bit ALU attached to the sequencer.
module tb_alu_nibble_sequencer;
  logic clk = 0, rst = 1;
  logic cmd_valid = 0, cmd_ready, rsp_valid, rsp_ready = 0, rsp_carry, rsp_err, alu_carry;
  logic [2:0] cmd_op = 0, alu_sel;
  logic [15:0] cmd_a = 0, cmd_b = 0, rsp_result;
  logic [3:0] alu_a, alu_b, alu_result;
  int vectors = 0, miscompares = 0;

  typedef struct {
    logic [15:0] res;
    logic carry;
    logic err;
    int lat;
    int ones;
  } exp_t;
  exp_t sb[$];

  alu_nibble_sequencer #(.NIBBLES(4)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_err(rsp_err), .alu_a(alu_a),
    .alu_b(alu_b), .alu_sel(alu_sel), .alu_result(alu_result), .alu_carry(alu_carry)
  );

  always #5 clk = ~clk;

  always_comb begin
    alu_result = 4'h0;
    alu_carry = 1'b0;
    case (alu_sel)
      3'b000: {alu_carry, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
      3'b001: begin alu_result = alu_a - alu_b; alu_carry = alu_a < alu_b; end
      3'b010: alu_result = alu_a & alu_b;
      3'b011: alu_result = alu_a | alu_b;
      3'b100: alu_result = alu_a ^ alu_b;
      3'b111: alu_result = ~alu_a;
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    logic [16:0] s;
    int f = 0;
    e.err = op == 3'b101 || op == 3'b110;
    e.carry = 0;
    e.res = 0;
    case (op)
      3'b000: begin s = {1'b0, a} + {1'b0, b}; e.res = s[15:0]; e.carry = s[16]; end
      3'b001: begin e.res = a - b; e.carry = a < b; end
      3'b010: e.res = a & b;
      3'b011: e.res = a | b;
      3'b100: e.res = a ^ b;
      3'b111: e.res = ~a;
      default: ;
    endcase
    // a FIX cycle happens for every nibble that receives a carry/borrow from below
    for (int i = 1; i < 4; i++) begin
      int m, am, bm;
      m = (1 << (4 * i)) - 1;
      am = int'(a) & m;
      bm = int'(b) & m;
      if (op == 3'b000 && ((am + bm) >> (4 * i)) != 0) f++;
      if (op == 3'b001 && am < bm) f++;
    end
    e.lat = e.err ? 0 : 4 + f;
    e.ones = f;
    if (!e.err && op != 3'b111)
      for (int i = 0; i < 4; i++) if (((b >> (4 * i)) & 16'hF) == 16'h1) e.ones++;
    return e;
  endfunction

  task automatic run(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b, input int hold);
    exp_t e;
    int lat = 0, ones = 0;
    bit sel_ok = 1, stable = 1;
    logic [17:0] snap;
    chk("cmd_ready", cmd_ready, 1);
    cmd_valid = 1; cmd_op = op; cmd_a = a; cmd_b = b;
    @(posedge clk);
    sb.push_back(model(op, a, b));
    @(negedge clk);
    cmd_valid = 0;
    while (!rsp_valid && lat < 40) begin
      if (alu_sel != op) sel_ok = 0;
      if (alu_b == 4'h1) ones++;
      if (cmd_ready) sel_ok = 0;
      lat++;
      @(negedge clk);
    end
    e = sb.pop_front();
    chk("rsp_valid", rsp_valid, 1);
    chk("result", rsp_result, e.res);
    chk("carry", rsp_carry, e.carry);
    chk("err", rsp_err, e.err);
    chk("latency", lat, e.lat);
    chk("ones_b", ones, e.ones);
    chk("sel_run", sel_ok, 1);
    chk("sel_done", {alu_sel, alu_a, alu_b}, 0);
    snap = {rsp_result, rsp_carry, rsp_err};
    repeat (hold) begin
      @(negedge clk);
      if ({rsp_result, rsp_carry, rsp_err} != snap || !rsp_valid || cmd_ready) stable = 0;
    end
    if (hold > 0) chk("hold", stable, 1);
    rsp_ready = 1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 0;
    chk("rsp_drop", rsp_valid, 0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ready"}, cmd_ready, 1);
    chk({tag, "_rsp"}, {rsp_valid, rsp_result, rsp_carry, rsp_err}, 0);
    chk({tag, "_alu"}, {alu_a, alu_b, alu_sel}, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 0;
    chk_reset("reset");
    run(3'b000, 16'h00FF, 16'h0001, 0);
    run(3'b000, 16'hFFFF, 16'h0001, 0);
    run(3'b000, 16'h1234, 16'h4321, 0);
    run(3'b001, 16'h1000, 16'h0001, 0);
    run(3'b001, 16'h0000, 16'h0001, 0);
    run(3'b100, 16'hA5A5, 16'hFFFF, 0);
    run(3'b111, 16'h0F0F, 16'h1111, 0);
    run(3'b101, 16'h1234, 16'h5678, 0);
    run(3'b110, 16'hFFFF, 16'hFFFF, 5);
    run(3'b001, 16'h8421, 16'h1248, 5);
    for (int i = 0; i < 8; i++)
      run(3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom), 0);
    cmd_valid = 1; cmd_op = 3'b000; cmd_a = 16'h1234; cmd_b = 16'h4321;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 0;
    repeat (2) @(negedge clk);
    chk("op2_a", alu_a, 4'h2);
    rst = 1;
    #1;
    chk_reset("midrst");
    @(negedge clk);
    rst = 0;
    run(3'b000, 16'h0FFF, 16'hF001, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
